// File: rtl/throw_capture.sv
// throw_capture: synchronises and debounces the six player buttons, locks each
// player's first one-hot throw, reveals both choices together and pulses
// commit once per round before waiting for every button to be released.
module throw_capture #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REVEAL_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       btn_rock1,
  input  logic       btn_paper1,
  input  logic       btn_scissors1,
  input  logic       btn_rock2,
  input  logic       btn_paper2,
  input  logic       btn_scissors2,
  output logic       rock1,
  output logic       paper1,
  output logic       scissors1,
  output logic       rock2,
  output logic       paper2,
  output logic       scissors2,
  output logic       locked1,
  output logic       locked2,
  output logic       commit,
  output logic [1:0] state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REVEAL_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // A throw is usable only when exactly one of rock/paper/scissors is down.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Bit order: [2:0] player 1 {scissors,paper,rock}, [5:3] player 2 likewise.
  logic [5:0]    raw_s;
  logic [5:0]    sync1_d, sync1_q;
  logic [5:0]    sync2_d, sync2_q;
  logic [5:0]    db_d, db_q;
  logic [DW-1:0] cnt_d [0:5];
  logic [DW-1:0] cnt_q [0:5];

  state_e        state_d, state_q;
  logic [RW-1:0] rcnt_d, rcnt_q;
  logic          lock1_d, lock1_q, lock2_d, lock2_q;
  logic [2:0]    hid1_d, hid1_q, hid2_d, hid2_q;
  logic [2:0]    choice1_d, choice1_q, choice2_d, choice2_q;
  logic          commit_d, commit_q;

  assign raw_s = {btn_scissors2, btn_paper2, btn_rock2,
                  btn_scissors1, btn_paper1, btn_rock1};

  // Two-stage synchroniser and per-button debounce counters.
  always_comb begin
    sync1_d = raw_s;
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = {DW{1'b0}};
      end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        // This edge is the required run of differing samples: accept it.
        db_d[i]  = sync2_q[i];
        cnt_d[i] = {DW{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  // Register synchroniser, debounced values and debounce counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 6'b0;
      sync2_q <= 6'b0;
      db_q    <= 6'b0;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= {DW{1'b0}};
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // Round sequencing: lock throws, reveal, commit, then wait for release.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    lock1_d   = lock1_q;
    lock2_d   = lock2_q;
    hid1_d    = hid1_q;
    hid2_d    = hid2_q;
    choice1_d = choice1_q;
    choice2_d = choice2_q;
    commit_d  = 1'b0;
    if (new_game) begin
      state_d   = ST_WAIT;
      rcnt_d    = {RW{1'b0}};
      lock1_d   = 1'b0;
      lock2_d   = 1'b0;
      hid1_d    = 3'b000;
      hid2_d    = 3'b000;
      choice1_d = 3'b000;
      choice2_d = 3'b000;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (lock1_q && lock2_q) begin
            state_d   = ST_SETTLE;
            rcnt_d    = {RW{1'b0}};
            choice1_d = hid1_q;
            choice2_d = hid2_q;
          end else begin
            // First unambiguous throw wins; later presses are ignored.
            if (!lock1_q && is_onehot3(db_q[2:0])) begin
              lock1_d = 1'b1;
              hid1_d  = db_q[2:0];
            end else begin
              lock1_d = lock1_q;
            end
            if (!lock2_q && is_onehot3(db_q[5:3])) begin
              lock2_d = 1'b1;
              hid2_d  = db_q[5:3];
            end else begin
              lock2_d = lock2_q;
            end
          end
        end
        ST_SETTLE: begin
          if (rcnt_q == RW'(REVEAL_CYCLES - 1)) begin
            state_d  = ST_COMMIT;
            rcnt_d   = {RW{1'b0}};
            commit_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        ST_COMMIT: begin
          state_d = ST_HOLD;
        end
        ST_HOLD: begin
          // Held buttons keep us here so a stale press cannot start a round.
          if (db_q == 6'b0) begin
            state_d   = ST_WAIT;
            lock1_d   = 1'b0;
            lock2_d   = 1'b0;
            hid1_d    = 3'b000;
            hid2_d    = 3'b000;
            choice1_d = 3'b000;
            choice2_d = 3'b000;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d   = ST_WAIT;
          rcnt_d    = {RW{1'b0}};
          lock1_d   = 1'b0;
          lock2_d   = 1'b0;
          hid1_d    = 3'b000;
          hid2_d    = 3'b000;
          choice1_d = 3'b000;
          choice2_d = 3'b000;
        end
      endcase
    end
  end

  // FSM state, locks, hidden throws and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_WAIT;
      rcnt_q    <= {RW{1'b0}};
      lock1_q   <= 1'b0;
      lock2_q   <= 1'b0;
      hid1_q    <= 3'b000;
      hid2_q    <= 3'b000;
      choice1_q <= 3'b000;
      choice2_q <= 3'b000;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      lock1_q   <= lock1_d;
      lock2_q   <= lock2_d;
      hid1_q    <= hid1_d;
      hid2_q    <= hid2_d;
      choice1_q <= choice1_d;
      choice2_q <= choice2_d;
      commit_q  <= commit_d;
    end
  end

  assign rock1     = choice1_q[0];
  assign paper1    = choice1_q[1];
  assign scissors1 = choice1_q[2];
  assign rock2     = choice2_q[0];
  assign paper2    = choice2_q[1];
  assign scissors2 = choice2_q[2];
  assign locked1   = lock1_q;
  assign locked2   = lock2_q;
  assign commit    = commit_q;
  assign state     = state_q;

endmodule

// File: doc/throw_capture.md
# throw_capture

Front-end input stage for the rock-paper-scissors scorer. It synchronises and debounces the six player push-buttons and locks each player's first unambiguous throw. Once both players have locked, it drives stable one-hot choice lines and issues a single `commit` pulse that the scoring stage uses as its round trigger. It then waits for all buttons to be released before arming the next round.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronised button must differ from its debounced value before the debounced value flips (≥1).
- `REVEAL_CYCLES`, default 4: cycles the choice lines are held stable before `commit` (≥1).

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset: asynchronous, active-low.
- `new_game`  in  1  synchronous abort: return to WAIT and clear locks and choices.
- `btn_rock1`, `btn_paper1`, `btn_scissors1`  in  1 each  raw, asynchronous player-1 buttons, active-high.
- `btn_rock2`, `btn_paper2`, `btn_scissors2`  in  1 each  raw player-2 buttons.
- `rock1`, `paper1`, `scissors1`  out  1 each  registered player-1 choice; one-hot or all-zero.
- `rock2`, `paper2`, `scissors2`  out  1 each  registered player-2 choice.
- `locked1`, `locked2`  out  1 each  player has a latched throw.
- `commit`  out  1  one-cycle round-valid pulse.
- `state`  out  2  FSM state: WAIT=0, SETTLE=1, COMMIT=2, HOLD=3.

## Operation
- **Synchroniser:** per button, a 2-flop synchroniser, reset to 0.
- **Debouncer:** per button, a counter of width clog2(DEBOUNCE_CYCLES+1).
  - When the synchronised value equals the debounced value, the counter clears.
  - Otherwise the counter increments. On the DEBOUNCE_CYCLES-th consecutive differing edge, the debounced value takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- **Lock rule:** in WAIT, for each unlocked player:
  - If the debounced 3-bit vector is exactly one-hot, latch it into a hidden choice register and set `lockedN`.
  - If the vector is zero or has ≥2 bits set, nothing happens.
  - Once locked, that player's further presses are ignored until the next WAIT entry from HOLD or `new_game`.
  - Both players may lock on the same edge.
- **FSM:**
  - WAIT → SETTLE on the edge after `locked1` & `locked2` are both 1. Choice outputs load the hidden registers on that edge.
  - SETTLE holds for REVEAL_CYCLES cycles via a counter, then goes to COMMIT.
  - COMMIT lasts exactly 1 cycle with `commit`=1, then goes to HOLD.
  - HOLD → WAIT on the edge after all six debounced buttons are 0. On entry to WAIT, locks, hidden registers and choice outputs clear.
- **Choice outputs** are 0 in WAIT, so throws stay hidden until both players lock. They are stable and unchanged from SETTLE entry through the end of HOLD.
- **Ties** (same throw from both players) are committed normally; scoring decides the result.
- **`new_game`:** from any state, the next state is WAIT and locks, choices, the SETTLE counter and `commit` clear.
  - Debouncer state is untouched.
  - Priority: `rst` > `new_game` > FSM transitions.

## Timing
- **Reset values:** every output is 0 and `state`=WAIT. All synchroniser flops, debounced values, counters, locks and hidden registers are 0.
- **Press latency** (raw stable before edge 1):
  - synchronised high after edge 2;
  - debounced high after edge 2+DEBOUNCE_CYCLES;
  - locked after edge 3+DEBOUNCE_CYCLES.
- **Reveal and commit latency:**
  - Choice outputs are valid 1 edge after the second lock.
  - `commit` asserts REVEAL_CYCLES edges after that and lasts 1 cycle.
- **Release latency:** WAIT re-entry occurs 1 edge after the last debounced button falls (2+DEBOUNCE_CYCLES edges after the raw release).
- **Reset mid-operation:** `rst` low asynchronously clears everything, including a `commit` that is high. Operation resumes on the first edge after `rst` rises.
- **Held buttons:** a button still held from the previous round keeps HOLD active. It cannot cause a new lock until it is released and pressed again.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REVEAL_CYCLES=2.
- **Reset:** assert `rst`=0 mid-SETTLE → all outputs 0 immediately and `state`=0. Release `rst` → the bench observes WAIT with no `commit` pulse.
- **Basic round:** `btn_rock1` and `btn_scissors2` rise before edge 1.
  - Required: `locked1`/`locked2`=1 after edge 7; `rock1`=`scissors2`=1 after edge 8; `commit`=1 only during the cycle after edge 10; `state`=3 after edge 11.
  - Release both buttons → `state`=0 after edge 17, and all choices are 0.
- **Bounce:** `btn_paper1` high for 3 cycles, low 1 cycle, then high → no lock until 4 consecutive synchronised-high cycles. Exactly one lock results, with `paper1` latched.
- **Ambiguous press:** `btn_rock1` and `btn_paper1` held together → `locked1` stays 0. Releasing `btn_paper1` → the lock is rock 5 edges after the release reaches the synchroniser.
- **Late change:** player 1 locks rock, then switches to scissors before player 2 presses → `rock1`=1 at reveal. Player 2's paper gives `paper2`=1 and one `commit`.
- **`new_game`** pulsed during HOLD with buttons still held → `state`=0 and choices 0 on the next edge. The held buttons relock immediately because they are still debounced-high one-hot; the bench checks `locked1`=`locked2`=1 on the following edge.
